// File: rtl/window3x3_stream.sv
// Streaming 3x3 neighbourhood generator: two circular line buffers, a two-column
// shift window and one output register stage. WIN_ZERO_PAD_EN enables edge windows.
module window3x3_stream #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 10,
    parameter int IMG_H  = 10
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  start,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_W-1:0]     s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [9*DATA_W-1:0]   win_data,
    output logic                  complete
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int DW = $clog2(IMG_W + 2);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
`ifdef WIN_ZERO_PAD_EN
    localparam logic [XW-1:0] CX_FIRST = '0;
    localparam logic [YW-1:0] CY_FIRST = '0;
    localparam logic [XW-1:0] CX_LAST  = X_LAST;
    localparam logic [YW-1:0] CY_LAST  = Y_LAST;
`else
    localparam logic [XW-1:0] CX_FIRST = XW'(1);
    localparam logic [YW-1:0] CY_FIRST = YW'(1);
    localparam logic [XW-1:0] CX_LAST  = XW'(IMG_W - 2);
    localparam logic [YW-1:0] CY_LAST  = YW'(IMG_H - 2);
`endif

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t              state_r;
    logic [XW-1:0]       in_x_r, cx_r;
    logic [YW-1:0]       in_y_r, cy_r;
    logic [DW-1:0]       drain_cnt_r;
    logic                eof_r, fin_r, start_pend_r;
    logic [DATA_W-1:0]   lb1_r [IMG_W];
    logic [DATA_W-1:0]   lb2_r [IMG_W];
    logic [DATA_W-1:0]   c1_r [3];
    logic [DATA_W-1:0]   c2_r [3];
    logic [DATA_W-1:0]   col_s [3];
    logic                adv_s, inject_s, push_s, emit_s, last_pix_s, final_s;
    logic [9*DATA_W-1:0] next_win_s;
    logic [DATA_W-1:0]   slot_s;

`ifdef WIN_ZERO_PAD_EN
    function automatic logic edge_masked(input int r, input int c,
                                         input logic [XW-1:0] cx, input logic [YW-1:0] cy);
        return ((c == 0) && (cx == '0)) || ((c == 2) && (cx == X_LAST)) ||
               ((r == 0) && (cy == '0)) || ((r == 2) && (cy == Y_LAST));
    endfunction
`endif

    // Handshake, injection and emission decisions for the current cycle
    always_comb begin
        adv_s   = ~m_valid | m_ready;
        s_ready = (state_r == RUN) & ~eof_r & adv_s;
`ifdef WIN_ZERO_PAD_EN
        inject_s = (state_r == DRAIN) & (drain_cnt_r <= DW'(IMG_W)) & adv_s;
        emit_s   = inject_s | (s_valid & s_ready &
                   ((in_y_r >= YW'(2)) | ((in_y_r == YW'(1)) & (in_x_r != '0))));
`else
        inject_s = 1'b0;
        emit_s   = s_valid & s_ready & (in_y_r >= YW'(2)) & (in_x_r >= XW'(2));
`endif
        push_s     = (s_valid & s_ready) | inject_s;
        col_s[0]   = lb2_r[in_x_r];
        col_s[1]   = lb1_r[in_x_r];
        col_s[2]   = inject_s ? '0 : s_data;
        last_pix_s = (in_x_r == X_LAST) & (in_y_r == Y_LAST);
        final_s    = (cx_r == CX_LAST) & (cy_r == CY_LAST);
    end

    // Assemble the next window: two stored columns plus the incoming one
    always_comb begin
        next_win_s = '0;
        slot_s     = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                slot_s = (c == 0) ? c1_r[r] : ((c == 1) ? c2_r[r] : col_s[r]);
`ifdef WIN_ZERO_PAD_EN
                slot_s = edge_masked(r, c, cx_r, cy_r) ? '0 : slot_s;
`endif
                next_win_s[(r*3+c)*DATA_W +: DATA_W] = slot_s;
            end
        end
    end

    // Line buffers are never cleared; stale rows are masked or never emitted
    always_ff @(posedge CLK) begin
        if (push_s) begin
            lb2_r[in_x_r] <= lb1_r[in_x_r];
            lb1_r[in_x_r] <= col_s[2];
        end
    end

    // Column shift registers feeding the window
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int r = 0; r < 3; r++) begin
                c1_r[r] <= '0;
                c2_r[r] <= '0;
            end
        end else if (push_s) begin
            for (int r = 0; r < 3; r++) begin
                c1_r[r] <= c2_r[r];
                c2_r[r] <= col_s[r];
            end
        end
    end

    // Frame FSM, counters and registered output stage
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r      <= IDLE;
            in_x_r       <= '0;
            in_y_r       <= '0;
            cx_r         <= '0;
            cy_r         <= '0;
            drain_cnt_r  <= '0;
            eof_r        <= 1'b0;
            fin_r        <= 1'b0;
            start_pend_r <= 1'b0;
            m_valid      <= 1'b0;
            win_data     <= '0;
            complete     <= 1'b0;
        end else begin
            complete <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start | start_pend_r) begin
                        state_r      <= RUN;
                        in_x_r       <= '0;
                        in_y_r       <= '0;
                        cx_r         <= CX_FIRST;
                        cy_r         <= CY_FIRST;
                        drain_cnt_r  <= '0;
                        eof_r        <= 1'b0;
                        fin_r        <= 1'b0;
                        start_pend_r <= 1'b0;
                    end
                end
                RUN: begin
                    if (s_valid & s_ready) begin
                        if (last_pix_s) begin
                            in_x_r <= '0;
                            eof_r  <= 1'b1;
`ifdef WIN_ZERO_PAD_EN
                            state_r <= DRAIN;
`endif
                        end else if (in_x_r == X_LAST) begin
                            in_x_r <= '0;
                            in_y_r <= in_y_r + YW'(1);
                        end else begin
                            in_x_r <= in_x_r + XW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (inject_s) begin
                        drain_cnt_r <= drain_cnt_r + DW'(1);
                        in_x_r      <= (in_x_r == X_LAST) ? '0 : in_x_r + XW'(1);
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    if (start) begin
                        start_pend_r <= 1'b1;
                    end
                end
                default: state_r <= IDLE;
            endcase

            if (adv_s) begin
                m_valid <= emit_s;
                if (emit_s) begin
                    win_data <= next_win_s;
                    if (final_s) begin
                        fin_r <= 1'b1;
                    end
                    if (cx_r == CX_LAST) begin
                        cx_r <= CX_FIRST;
                        cy_r <= cy_r + YW'(1);
                    end else begin
                        cx_r <= cx_r + XW'(1);
                    end
                end
            end

            if (m_valid & m_ready & fin_r) begin
                state_r  <= DONE;
                complete <= 1'b1;
                fin_r    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_window3x3_stream.sv
// Bench for window3x3_stream: a 4x4 directed instance and a 10x10 randomized
// instance checked against a coordinate-based window model.
module tb_window3x3_stream;
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;
    logic RESET;

    logic        start, s_valid, s_ready, m_valid, m_ready, complete;
    logic [7:0]  s_data;
    logic [71:0] win_data;
    logic        a_start, a_s_valid, a_s_ready, a_m_valid, a_m_ready, a_complete;
    logic [7:0]  a_s_data;
    logic [71:0] a_win_data;

    window3x3_stream #(.DATA_W(8), .IMG_W(10), .IMG_H(10)) u10 (
        .CLK(CLK), .RESET(RESET), .start(start), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready), .win_data(win_data),
        .complete(complete));

    window3x3_stream #(.DATA_W(8), .IMG_W(4), .IMG_H(4)) u4 (
        .CLK(CLK), .RESET(RESET), .start(a_start), .s_valid(a_s_valid), .s_ready(a_s_ready),
        .s_data(a_s_data), .m_valid(a_m_valid), .m_ready(a_m_ready), .win_data(a_win_data),
        .complete(a_complete));

    int vecs = 0;
    int errs = 0;
    logic [71:0] got[$];
    logic [71:0] a_got[$];
    logic [71:0] exp_q[$];
    int comp_cnt = 0;
    int a_comp_cnt = 0;
    int img[100];
    int sv_rand, mr_rand, stall_at, start_at, abort_at, no_start, chain;

    // Output monitor: collects accepted windows and complete pulses
    always @(negedge CLK) begin
        if (!RESET) begin
            if (m_valid && m_ready) got.push_back(win_data);
            if (complete) comp_cnt++;
            if (a_m_valid && a_m_ready) a_got.push_back(a_win_data);
            if (a_complete) a_comp_cnt++;
        end
    end

    function automatic logic [71:0] model_win(int cx, int cy);
        logic [71:0] w = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                int x = cx + c - 1;
                int y = cy + r - 1;
                if (x >= 0 && x < 10 && y >= 0 && y < 10) w[(r*3+c)*8 +: 8] = 8'(img[y*10+x]);
            end
        return w;
    endfunction

    task automatic build_exp();
        exp_q.delete();
`ifdef WIN_ZERO_PAD_EN
        for (int cy = 0; cy < 10; cy++) for (int cx = 0; cx < 10; cx++) exp_q.push_back(model_win(cx, cy));
`else
        for (int cy = 1; cy < 9; cy++) for (int cx = 1; cx < 9; cx++) exp_q.push_back(model_win(cx, cy));
`endif
    endtask

    task automatic randomize_img();
        for (int i = 0; i < 100; i++) img[i] = int'($urandom_range(0, 255));
    endtask

    task automatic default_knobs();
        sv_rand = 0; mr_rand = 0; stall_at = -1; start_at = -1; abort_at = -1; no_start = 0; chain = 0;
    endtask

    // Drives one 10x10 frame according to the knobs; done=1 once complete is seen
    task automatic drive_frame(output bit done);
        int idx = 0;
        int cyc = 0;
        int stall_left = 0;
        bit stalled = 1'b0;
        bit acc;
        done = 1'b0;
        if (no_start == 0) begin
            @(posedge CLK); #1 start = 1'b1;
            @(posedge CLK); #1 start = 1'b0;
        end
        while (idx < 100 && cyc < 5000) begin
            s_valid = (sv_rand != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_data  = 8'(img[idx]);
            if (idx == stall_at && !stalled) begin stall_left = 5; stalled = 1'b1; end
            m_ready = (stall_left > 0) ? 1'b0 : ((mr_rand != 0) ? ($urandom_range(0, 3) != 0) : 1'b1);
            if (stall_left > 0) stall_left--;
            start = (idx == start_at);
            @(negedge CLK); acc = s_valid && s_ready;
            @(posedge CLK); #1;
            if (acc) idx++;
            cyc++;
            if (idx == abort_at) break;
        end
        s_valid = 1'b0;
        start = 1'b0;
        if (idx != abort_at) begin
            for (int k = 0; k < 500 && !done; k++) begin
                m_ready = (mr_rand != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
                @(negedge CLK);
                if (complete) begin
                    done = 1'b1;
                    start = (chain != 0);
                end
                @(posedge CLK); #1;
                start = 1'b0;
            end
        end
        m_ready = 1'b1;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        vecs++; if (s_ready !== 1'b0) begin errs++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
        vecs++; if (m_valid !== 1'b0) begin errs++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
        vecs++; if (win_data !== 72'd0) begin errs++; $display("FAIL reset_win_data: got %h want 0", win_data); end
        vecs++; if (complete !== 1'b0) begin errs++; $display("FAIL reset_complete: got %b want 0", complete); end
        vecs++; if (a_m_valid !== 1'b0) begin errs++; $display("FAIL reset4_m_valid: got %b want 0", a_m_valid); end
        vecs++; if (a_win_data !== 72'd0) begin errs++; $display("FAIL reset4_win_data: got %h want 0", a_win_data); end
        RESET = 1'b0;
        s_valid = 1'b1; a_s_valid = 1'b1;
        @(negedge CLK);
        vecs++; if (s_ready !== 1'b0) begin errs++; $display("FAIL idle_s_ready: got %b want 0", s_ready); end
        vecs++; if (a_s_ready !== 1'b0) begin errs++; $display("FAIL idle4_s_ready: got %b want 0", a_s_ready); end
        @(posedge CLK); #1;
        s_valid = 1'b0; a_s_valid = 1'b0;
    endtask

    task automatic test_small_frame();
        int base = a_got.size();
        int c0 = a_comp_cnt;
        int idx = 0;
        int cyc = 0;
        int trig;
        bit acc, chk_lat, done;
        int fe[9], le[9];
        logic [71:0] fw, lw;
        int nwin;
`ifdef WIN_ZERO_PAD_EN
        fe = '{0, 0, 0, 0, 1, 2, 0, 5, 6};
        le = '{11, 12, 0, 15, 16, 0, 0, 0, 0};
        nwin = 16; trig = 5;
`else
        fe = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
        le = '{6, 7, 8, 10, 11, 12, 14, 15, 16};
        nwin = 4; trig = 10;
`endif
        for (int k = 0; k < 9; k++) begin fw[k*8 +: 8] = 8'(fe[k]); lw[k*8 +: 8] = 8'(le[k]); end
        chk_lat = 1'b0; done = 1'b0;
        a_m_ready = 1'b1;
        @(posedge CLK); #1 a_start = 1'b1;
        @(posedge CLK); #1 a_start = 1'b0;
        while (idx < 16 && cyc < 200) begin
            a_s_valid = 1'b1; a_s_data = 8'(idx + 1);
            @(negedge CLK);
            if (chk_lat) begin
                chk_lat = 1'b0;
                vecs++; if (a_m_valid !== 1'b1) begin errs++; $display("FAIL latency4: m_valid %b want 1", a_m_valid); end
            end
            acc = a_s_valid && a_s_ready;
            @(posedge CLK); #1;
            if (acc) begin chk_lat = (idx == trig); idx++; end
            cyc++;
        end
`ifdef WIN_ZERO_PAD_EN
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            vecs++; if (a_s_ready !== 1'b0) begin errs++; $display("FAIL drain4_s_ready[%0d]: got %b want 0", k, a_s_ready); end
            @(posedge CLK); #1;
        end
`endif
        a_s_valid = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge CLK); if (a_complete) done = 1'b1;
            @(posedge CLK); #1;
        end
        repeat (3) @(posedge CLK);
        #1;
        vecs++; if (!done) begin errs++; $display("FAIL small_timeout: complete %b want 1", done); end
        vecs++; if (a_comp_cnt - c0 != 1) begin errs++; $display("FAIL small_complete: %0d pulses want 1", a_comp_cnt - c0); end
        vecs++; if (a_got.size() - base != nwin) begin errs++; $display("FAIL small_count: got %0d want %0d", a_got.size() - base, nwin); end
        if (a_got.size() - base >= 1) begin
            vecs++; if (a_got[base] !== fw) begin errs++; $display("FAIL small_first: got %h want %h", a_got[base], fw); end
            vecs++; if (a_got[a_got.size()-1] !== lw) begin errs++; $display("FAIL small_last: got %h want %h", a_got[a_got.size()-1], lw); end
        end
    endtask

    task automatic test_random_frame();
        int base, c0, n;
        bit done;
        default_knobs(); sv_rand = 1; mr_rand = 1;
        randomize_img(); build_exp();
        base = got.size(); c0 = comp_cnt;
        drive_frame(done);
        n = got.size() - base;
        vecs++; if (!done || n != exp_q.size()) begin errs++; $display("FAIL rand_count: done %b got %0d want %0d", done, n, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < n; i++) begin
            vecs++; if (got[base+i] !== exp_q[i]) begin errs++; $display("FAIL rand_win[%0d]: got %h want %h", i, got[base+i], exp_q[i]); end
        end
        vecs++; if (comp_cnt - c0 != 1) begin errs++; $display("FAIL rand_complete: %0d pulses want 1", comp_cnt - c0); end
    endtask

    task automatic test_backpressure();
        int base, n;
        bit done;
        default_knobs(); stall_at = 45;
        randomize_img(); build_exp();
        base = got.size();
        fork
            drive_frame(done);
            begin
                logic [71:0] held;
                int k = 0;
                int s = 0;
                while (m_ready !== 1'b0 && k < 3000) begin @(negedge CLK); k++; end
                vecs++; if (k >= 3000) begin errs++; $display("FAIL bp_timeout: stall %0d want 1", 0); end
                held = win_data;
                while (m_ready === 1'b0 && s < 10) begin
                    vecs++; if (s_ready !== 1'b0) begin errs++; $display("FAIL bp_s_ready[%0d]: got %b want 0", s, s_ready); end
                    vecs++; if (m_valid !== 1'b1) begin errs++; $display("FAIL bp_m_valid[%0d]: got %b want 1", s, m_valid); end
                    if (s > 0) begin
                        vecs++; if (win_data !== held) begin errs++; $display("FAIL bp_hold[%0d]: got %h want %h", s, win_data, held); end
                    end
                    s++;
                    @(negedge CLK);
                end
            end
        join
        n = got.size() - base;
        vecs++; if (!done || n != exp_q.size()) begin errs++; $display("FAIL bp_count: done %b got %0d want %0d", done, n, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < n; i++) begin
            vecs++; if (got[base+i] !== exp_q[i]) begin errs++; $display("FAIL bp_win[%0d]: got %h want %h", i, got[base+i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        int base, n;
        bit done;
        default_knobs(); abort_at = 20;
        randomize_img();
        drive_frame(done);
        RESET = 1'b1;
        @(posedge CLK); #1;
        vecs++; if (s_ready !== 1'b0) begin errs++; $display("FAIL rst_mid_s_ready: got %b want 0", s_ready); end
        vecs++; if (m_valid !== 1'b0) begin errs++; $display("FAIL rst_mid_m_valid: got %b want 0", m_valid); end
        vecs++; if (win_data !== 72'd0) begin errs++; $display("FAIL rst_mid_win_data: got %h want 0", win_data); end
        vecs++; if (complete !== 1'b0) begin errs++; $display("FAIL rst_mid_complete: got %b want 0", complete); end
        RESET = 1'b0;
        default_knobs(); sv_rand = 1;
        randomize_img(); build_exp();
        base = got.size();
        drive_frame(done);
        n = got.size() - base;
        vecs++; if (!done || n != exp_q.size()) begin errs++; $display("FAIL rst_mid_count: done %b got %0d want %0d", done, n, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < n; i++) begin
            vecs++; if (got[base+i] !== exp_q[i]) begin errs++; $display("FAIL rst_mid_win[%0d]: got %h want %h", i, got[base+i], exp_q[i]); end
        end
    endtask

    task automatic test_start_during_run();
        int base, c0, n;
        bit done;
        default_knobs(); start_at = 30;
        randomize_img(); build_exp();
        base = got.size(); c0 = comp_cnt;
        drive_frame(done);
        n = got.size() - base;
        vecs++; if (!done || n != exp_q.size()) begin errs++; $display("FAIL start_run_count: done %b got %0d want %0d", done, n, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < n; i++) begin
            vecs++; if (got[base+i] !== exp_q[i]) begin errs++; $display("FAIL start_run_win[%0d]: got %h want %h", i, got[base+i], exp_q[i]); end
        end
        vecs++; if (comp_cnt - c0 != 1) begin errs++; $display("FAIL start_run_complete: %0d pulses want 1", comp_cnt - c0); end
    endtask

    task automatic test_back_to_back();
        int base, n;
        bit done;
        default_knobs(); chain = 1;
        randomize_img(); build_exp();
        drive_frame(done);
        vecs++; if (!done) begin errs++; $display("FAIL b2b_first: done %b want 1", done); end
        default_knobs(); no_start = 1;
        base = got.size();
        drive_frame(done);
        n = got.size() - base;
        vecs++; if (!done || n != exp_q.size()) begin errs++; $display("FAIL b2b_count: done %b got %0d want %0d", done, n, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < n; i++) begin
            vecs++; if (got[base+i] !== exp_q[i]) begin errs++; $display("FAIL b2b_win[%0d]: got %h want %h", i, got[base+i], exp_q[i]); end
        end
    endtask

    initial begin
        RESET = 1'b1;
        start = 1'b0; s_valid = 1'b0; s_data = 8'd0; m_ready = 1'b1;
        a_start = 1'b0; a_s_valid = 1'b0; a_s_data = 8'd0; a_m_ready = 1'b1;
        test_reset();
        test_small_frame();
        test_random_frame();
        test_backpressure();
        test_reset_mid_frame();
        test_start_during_run();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/window3x3_stream.md
# window3x3_stream

Streaming 3×3 neighbourhood generator for the image pipeline. It replaces the fixed two-BRAM, 8-bit, hand-sequenced window readout with a parametrised block:
- Accepts one pixel per handshake in raster order.
- Buffers two image lines internally.
- Emits one complete 3×3 window per output handshake to the downstream filter stage.

Pixel width and frame size are parameters. Both ports carry valid/ready backpressure.

## Interface
- DATA_W, 8: pixel width in bits.
- IMG_W, 10: pixels per line, ≥3.
- IMG_H, 10: lines per frame, ≥3.
- CLK  in  1  sole clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that arms a frame; honoured only in IDLE.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  block accepts the pixel this cycle.
- s_data  in  DATA_W  input pixel, raster order.
- m_valid  out  1  window valid.
- m_ready  in  1  downstream accepts the window.
- win_data  out  9*DATA_W  window contents. Slot k occupies bits [k*DATA_W +: DATA_W], row-major. Slot 0 = (y-1,x-1), slot 4 = centre (y,x), slot 8 = (y+1,x+1).
- complete  out  1  one-cycle pulse after the final window of the frame is accepted.

## Operation
- **States:** IDLE, RUN, DRAIN, DONE.
- **IDLE:**
  - s_ready=0.
  - start → RUN.
  - Input counters in_x and in_y clear on entry to RUN.
- **RUN:**
  - A pixel is accepted when s_valid & s_ready.
  - Each accepted pixel is written into the line-buffer column in_x, and the 3×3 shift window advances one column.
  - Two line buffers, each IMG_W×DATA_W, are addressed circularly by in_x. Each buffer holds the line k-1 or k-2 pixels of the column.
  - in_x wraps at IMG_W-1 and increments in_y. The last pixel (IMG_W-1, IMG_H-1) → DRAIN when padding is enabled, otherwise → DONE.
- **Window emission:**
  - Pixel at linear index n triggers the window centred on linear index n-IMG_W-1.
  - Centre coordinates (cx,cy) are tracked by a separate output counter.
- **DRAIN** (padding build only):
  - s_ready=0.
  - The block injects IMG_W+1 virtual zero pixels, subject to the same m_ready stall rule, then → DONE.
- **DONE:**
  - Entered once the final window handshake completes.
  - complete=1 for one cycle, then → IDLE.
- **Backpressure:**
  - One output register stage.
  - s_ready = RUN & (~m_valid | m_ready).
  - Window advance and virtual-pixel injection stall under the same condition.
  - win_data holds stable while m_valid & ~m_ready.
- **Counter widths:** $clog2(IMG_W) for x counters and $clog2(IMG_H) for y counters. No arithmetic is performed on pixel data.
- **Simultaneous events:** start while not IDLE is ignored. s_valid outside RUN is ignored, with no write.
- **Reset mid-frame:** the partial frame is discarded and the block returns to IDLE. Line-buffer contents are not cleared; stale data is never visible because of masking or emission rules.

## Timing
- **Reset values:** state=IDLE, s_ready=0, m_valid=0, win_data=0, complete=0, all counters 0.
- **Latency:** m_valid rises in the cycle after the triggering pixel is accepted.
- **Throughput:** one window per cycle when s_valid and m_ready are held high.
- **complete timing:** asserted in the cycle after the final m_valid & m_ready.
- **Back-to-back frames:** the earliest next start is accepted in the cycle complete is high. That cycle is DONE, and start is registered into IDLE→RUN one cycle later.

## Configuration
- **WIN_ZERO_PAD_EN defined:**
  - IMG_W*IMG_H windows, one per pixel.
  - Slots outside the image read 0:
    - left column when cx=0;
    - right column when cx=IMG_W-1;
    - top row when cy=0;
    - bottom row when cy=IMG_H-1.
  - The DRAIN state is present.
- **WIN_ZERO_PAD_EN undefined:**
  - Only interior centres are emitted, 1≤cx≤IMG_W-2 and 1≤cy≤IMG_H-2, giving (IMG_W-2)*(IMG_H-2) windows.
  - No masking.
  - No DRAIN; RUN → DONE after the last pixel's window.

## Test plan
- **4×4 frame, no pad, start pulse, then pixels 1..16 with s_valid held:**
  - 4 windows.
  - First window slots 0..8 = {1,2,3,5,6,7,9,10,11}; last = {6,7,8,10,11,12,14,15,16}.
  - complete pulses once.
- **Same frame, WIN_ZERO_PAD_EN:**
  - 16 windows.
  - First = {0,0,0,0,1,2,0,5,6}; last = {11,12,0,15,16,0,0,0,0}.
  - s_ready=0 during the 5 drain cycles.
- **Backpressure, 10×10 frame, m_ready low for 5 cycles mid-frame:**
  - s_ready falls in the same cycle; win_data holds.
  - No pixel is lost or duplicated; 64 windows total.
- **Reset mid-frame:** RESET for 1 cycle after pixel 20 of a 10×10 frame → all outputs at reset values. A following full frame gives correct windows with no stale data.
- **start during RUN:** a pulse at pixel 30 is ignored, and the frame window count is unchanged.
- **Back-to-back:** start asserted in the complete cycle → the second frame's windows match the first for an identical input.
